// File: rtl/kp_pkg.sv
// Shared keypad definitions: key codes, checker state encoding and digit test.
// Used by the code checker and by the keypad capture register.
package kp_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   typedef enum logic [2:0] {
      ENTRY,
      CHECK,
      GRANT,
      DENY,
      LOCKED
   } state_t;

   function automatic logic is_digit(input logic [3:0] num);
      return (num <= 4'd9);
   endfunction

endpackage

// File: rtl/code_checker_if.sv
// Keypad-side inputs and decision/display outputs of the code checker.
interface code_checker_if #(
   parameter int DIGITS = 4
);
   logic                  found;
   logic [3:0]            num;
   logic [4*DIGITS-1:0]   entered;
   logic [3:0]            count;
   logic                  granted;
   logic                  denied;
   logic                  locked;
   logic [3:0]            fails;

   modport master (
      output found, num,
      input  entered, count, granted, denied, locked, fails
   );

   modport slave (
      input  found, num,
      output entered, count, granted, denied, locked, fails
   );
endinterface

// File: rtl/code_checker_key_edge.sv
// Turns the keypad "found" level into a one-cycle key event and keeps the last key code.
// The event and o_num are valid in the rising-edge cycle itself, so no latency is added.
module key_edge (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_found,
   input  logic [3:0] i_num,
   output logic       o_evt,
   output logic [3:0] o_num
);
   logic       r_found;
   logic [3:0] r_num;
   logic       w_evt;

   assign w_evt = i_found & ~r_found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_found <= 1'b0;
         r_num   <= 4'd0;
      end else begin
         r_found <= i_found;
         if (w_evt) r_num <= i_num;
      end
   end

   assign o_evt = w_evt;
   assign o_num = w_evt ? i_num : r_num;
endmodule

// File: rtl/code_checker.sv
// Access-code verifier: collects digits, compares on ENTER, holds grant/deny and
// enforces a timed lockout after too many consecutive failures.
//
//   state  | meaning
//   ENTRY  | collecting digits, CLEAR and ENTER accepted
//   CHECK  | one cycle: compare buffer against CODE, pick outcome
//   GRANT  | granted held for HOLD_CYCLES, keys ignored
//   DENY   | denied held for HOLD_CYCLES, keys ignored
//   LOCKED | locked held for LOCK_CYCLES, keys ignored, fails cleared on exit
module code_checker
   import kp_pkg::*;
#(
   parameter int                  DIGITS      = 4,
   parameter logic [4*DIGITS-1:0] CODE        = 16'h1234,
   parameter int                  MAX_TRIES   = 3,
   parameter int unsigned         HOLD_CYCLES = 50_000_000,
   parameter int unsigned         LOCK_CYCLES = 500_000_000
) (
   input logic            clk,
   input logic            rst_n,
   code_checker_if.slave  bus
);
   localparam longint unsigned MAX_CYC = (HOLD_CYCLES > LOCK_CYCLES) ? 64'(HOLD_CYCLES) : 64'(LOCK_CYCLES);
   localparam int              TW      = $clog2(MAX_CYC + 1);
   localparam int              EW      = 4 * DIGITS;

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic [EW-1:0]   r_entered;
   logic [3:0]      r_count;
   logic            r_granted;
   logic            r_denied;
   logic            r_locked;
   logic [3:0]      r_fails;

   logic            w_evt;
   logic [3:0]      w_key;
   logic [EW+3:0]   w_shift;
   logic            w_match;
   logic [3:0]      w_fails_inc;
   logic            w_timer_done;

   key_edge u_key_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_found (bus.found),
      .i_num   (bus.num),
      .o_evt   (w_evt),
      .o_num   (w_key)
   );

   // Shift in from the low nibble; the oldest digit falls off the top.
   assign w_shift      = {r_entered, w_key};
   // An ENTER with a short buffer can never match, even if the partial value happens to.
   assign w_match      = (r_count == 4'(DIGITS)) && (r_entered == CODE);
   assign w_fails_inc  = (r_fails == 4'hF) ? 4'hF : r_fails + 4'd1;
   assign w_timer_done = (r_timer <= TW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ENTRY;
         r_timer   <= '0;
         r_entered <= '0;
         r_count   <= 4'd0;
         r_granted <= 1'b0;
         r_denied  <= 1'b0;
         r_locked  <= 1'b0;
         r_fails   <= 4'd0;
      end else begin
         case (r_state)
            ENTRY: begin
               if (w_evt) begin
                  if (is_digit(w_key)) begin
                     if (r_count < 4'(DIGITS)) begin
                        r_entered <= w_shift[EW-1:0];
                        r_count   <= r_count + 4'd1;
                     end
                  end else if (w_key == KEY_CLEAR) begin
                     r_entered <= '0;
                     r_count   <= 4'd0;
                  end else if (w_key == KEY_ENTER) begin
                     r_state <= CHECK;
                  end
               end
            end
            CHECK: begin
               r_entered <= '0;
               r_count   <= 4'd0;
               if (w_match) begin
                  r_state   <= GRANT;
                  r_granted <= 1'b1;
                  r_fails   <= 4'd0;
                  r_timer   <= TW'(HOLD_CYCLES);
               end else begin
                  r_fails <= w_fails_inc;
                  if (w_fails_inc >= 4'(MAX_TRIES)) begin
                     r_state  <= LOCKED;
                     r_locked <= 1'b1;
                     r_timer  <= TW'(LOCK_CYCLES);
                  end else begin
                     r_state  <= DENY;
                     r_denied <= 1'b1;
                     r_timer  <= TW'(HOLD_CYCLES);
                  end
               end
            end
            GRANT, DENY: begin
               if (w_timer_done) begin
                  r_state   <= ENTRY;
                  r_granted <= 1'b0;
                  r_denied  <= 1'b0;
                  r_timer   <= '0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            LOCKED: begin
               if (w_timer_done) begin
                  r_state  <= ENTRY;
                  r_locked <= 1'b0;
                  r_fails  <= 4'd0;
                  r_timer  <= '0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: begin
               r_state   <= ENTRY;
               r_granted <= 1'b0;
               r_denied  <= 1'b0;
               r_locked  <= 1'b0;
               r_timer   <= '0;
            end
         endcase
      end
   end

   assign bus.entered = r_entered;
   assign bus.count   = r_count;
   assign bus.granted = r_granted;
   assign bus.denied  = r_denied;
   assign bus.locked  = r_locked;
   assign bus.fails   = r_fails;
endmodule

// File: tb/tb_code_checker.sv
// Directed bench for code_checker with short hold/lock times.
module tb_code_checker;
   import kp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   code_checker_if #(.DIGITS(4)) bus ();

   code_checker #(
      .DIGITS      (4),
      .CODE        (16'h1234),
      .MAX_TRIES   (3),
      .HOLD_CYCLES (8),
      .LOCK_CYCLES (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  key;
      logic [3:0]  e_count;
      logic [15:0] e_entered;
   } vec_t;

   vec_t tbl [10];

   task automatic press(input logic [3:0] k, input int hold);
      @(negedge clk);
      bus.num   = k;
      bus.found = 1'b1;
      repeat (hold) @(negedge clk);
      bus.found = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_digits(input logic [15:0] code, input int n);
      for (int i = 0; i < n; i++) press(code[4*(n-1-i) +: 4], 3);
   endtask

   // Issue ENTER and observe 40 cycles; a digit is pressed mid-window while keys must be ignored.
   task automatic run_enter(output int rise, output int g, output int d, output int l,
                            output int excl, output int fails_mid);
      @(negedge clk);
      bus.num   = KEY_ENTER;
      bus.found = 1'b1;
      rise = -1; g = 0; d = 0; l = 0; excl = 0; fails_mid = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if ((bus.granted || bus.denied || bus.locked) && rise < 0) rise = c;
         g += int'(bus.granted);
         d += int'(bus.denied);
         l += int'(bus.locked);
         if (int'(bus.granted) + int'(bus.denied) + int'(bus.locked) > 1) excl++;
         if (c == 5) fails_mid = int'(bus.fails);
         if (c == 3) bus.found = 1'b0;
         if (c == 8) begin bus.num = 4'd5; bus.found = 1'b1; end
         if (c == 10) bus.found = 1'b0;
      end
   endtask

   task automatic attempt(input string name, input logic [15:0] code, input int n,
                          input int eg, input int ed, input int el,
                          input int e_mid, input int e_fails);
      int rise, g, d, l, excl, fm;
      press_digits(code, n);
      run_enter(rise, g, d, l, excl, fm);
      chk({name, "_rise"}, rise, 2);
      chk({name, "_granted_len"}, g, eg);
      chk({name, "_denied_len"}, d, ed);
      chk({name, "_locked_len"}, l, el);
      chk({name, "_exclusive"}, excl, 0);
      chk({name, "_fails_mid"}, fm, e_mid);
      chk({name, "_fails_after"}, bus.fails, e_fails);
      chk({name, "_entered_after"}, bus.entered, 0);
      chk({name, "_count_after"}, bus.count, 0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_entered"}, bus.entered, 0);
      chk({name, "_count"}, bus.count, 0);
      chk({name, "_granted"}, bus.granted, 0);
      chk({name, "_denied"}, bus.denied, 0);
      chk({name, "_locked"}, bus.locked, 0);
      chk({name, "_fails"}, bus.fails, 0);
   endtask

   initial begin
      bit hit;
      bus.found = 1'b0;
      bus.num   = 4'd0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      tbl[0] = '{4'd1,      4'd1, 16'h0001};
      tbl[1] = '{4'd2,      4'd2, 16'h0012};
      tbl[2] = '{4'd3,      4'd3, 16'h0123};
      tbl[3] = '{4'd4,      4'd4, 16'h1234};
      tbl[4] = '{4'd9,      4'd4, 16'h1234};
      tbl[5] = '{4'hE,      4'd4, 16'h1234};
      tbl[6] = '{KEY_CLEAR, 4'd0, 16'h0000};
      tbl[7] = '{4'd7,      4'd1, 16'h0007};
      tbl[8] = '{4'd5,      4'd2, 16'h0075};
      tbl[9] = '{KEY_CLEAR, 4'd0, 16'h0000};
      for (int i = 0; i < 10; i++) begin
         press(tbl[i].key, 3);
         chk($sformatf("vec%0d_count", i), bus.count, tbl[i].e_count);
         chk($sformatf("vec%0d_entered", i), bus.entered, tbl[i].e_entered);
      end

      attempt("grant1",   16'h1234, 4, 8, 0, 0,  0, 0);
      attempt("wrong1",   16'h1235, 4, 0, 8, 0,  1, 1);
      attempt("short",    16'h0012, 2, 0, 8, 0,  2, 2);
      attempt("lockout",  16'h9999, 4, 0, 0, 20, 3, 0);
      attempt("grant2",   16'h1234, 4, 8, 0, 0,  0, 0);

      press(4'd7, 10);
      chk("held_count", bus.count, 1);
      chk("held_entered", bus.entered, 16'h0007);
      press(KEY_CLEAR, 3);

      // Reset in the middle of a grant hold.
      press_digits(16'h1234, 4);
      @(negedge clk);
      bus.num   = KEY_ENTER;
      bus.found = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 8 && !hit; c++) begin
         @(negedge clk);
         if (bus.granted) hit = 1'b1;
         if (c == 2) bus.found = 1'b0;
      end
      chk("mid_grant_reached", hit, 1);
      bus.found = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("mid_grant_rst");
      @(negedge clk);
      rst_n = 1'b1;
      press(4'd3, 3);
      chk("post_grant_rst_count", bus.count, 1);
      chk("post_grant_rst_entered", bus.entered, 16'h0003);
      press(KEY_CLEAR, 3);

      // Reset in the middle of a lockout.
      attempt("pre_lock1", 16'h1111, 4, 0, 8, 0, 1, 1);
      attempt("pre_lock2", 16'h1111, 4, 0, 8, 0, 2, 2);
      press_digits(16'h1111, 4);
      @(negedge clk);
      bus.num   = KEY_ENTER;
      bus.found = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 8 && !hit; c++) begin
         @(negedge clk);
         if (bus.locked) hit = 1'b1;
         if (c == 2) bus.found = 1'b0;
      end
      chk("mid_lock_reached", hit, 1);
      chk("mid_lock_fails", bus.fails, 3);
      chk("mid_lock_denied", bus.denied, 0);
      bus.found = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("mid_lock_rst");
      @(negedge clk);
      rst_n = 1'b1;
      press(4'd4, 3);
      chk("post_lock_rst_count", bus.count, 1);
      chk("post_lock_rst_entered", bus.entered, 16'h0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
